collected_tally: RTL

//  Consumes the maze-grid scan (x/y indices + end-of-scan pulse) from the check-collected scan counter.

---
 rtl/collected_tally_if.sv | 28 ++
 rtl/collected_tally.sv | 120 ++++++++++++
 2 files changed

// File: rtl/collected_tally_if.sv
// collected_tally_if: scan-in / map-RAM / round-result bundle for collected_tally.
// master: scan producer plus map RAM side. slave: the tally block.
interface collected_tally_if #(
    parameter int ADDR_W  = 11,
    parameter int COUNT_W = 10
);
    logic               scan_valid;
    logic [5:0]         scan_x;
    logic [5:0]         scan_y;
    logic               scan_done;
    logic               map_rd;
    logic [ADDR_W-1:0]  map_addr;
    logic [1:0]         map_rd_data;
    logic [COUNT_W-1:0] coins_left;
    logic               level_clear;
    logic               round_valid;
    logic [COUNT_W-1:0] wall_count;

    modport master (
        output scan_valid, scan_x, scan_y, scan_done, map_rd_data,
        input  map_rd, map_addr, coins_left, level_clear, round_valid, wall_count
    );

    modport slave (
        input  scan_valid, scan_x, scan_y, scan_done, map_rd_data,
        output map_rd, map_addr, coins_left, level_clear, round_valid, wall_count
    );
endinterface

// File: rtl/collected_tally.sv
// collected_tally: counts uncollected coin cells seen during a maze scan and
// publishes the round tally plus a level-clear flag four cycles after scan_done.
// Optional wall counter enabled by defining TALLY_WALL_COUNT_EN; otherwise
// wall_count is tied to zero.
module collected_tally #(
    parameter int         SIZE_X    = 40,
    parameter int         SIZE_Y    = 20,
    parameter int         ADDR_W    = 11,
    parameter int         COUNT_W   = 10,
    parameter logic [1:0] COIN_CODE = 2'd2,
    parameter logic [1:0] WALL_CODE = 2'd1
) (
    input logic              Clk,
    input logic              Reset,
    collected_tally_if.slave bus
);
    typedef enum logic [1:0] {SCAN, DRAIN1, DRAIN2, REPORT} state_t;

    state_t             state, state_nxt;
    logic               in_range;
    logic               accept;
    logic [ADDR_W-1:0]  addr_calc;
    logic               rd_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               rd_pend;
    logic [COUNT_W-1:0] coin_acc;
    logic [COUNT_W-1:0] coins_q;
    logic               clear_q;
    logic               rv_q;

    assign in_range  = (32'(bus.scan_x) < SIZE_X) && (32'(bus.scan_y) < SIZE_Y);
    assign accept    = (state == SCAN) && bus.scan_valid && in_range;
    assign addr_calc = ADDR_W'(bus.scan_y) * ADDR_W'(SIZE_X) + ADDR_W'(bus.scan_x);

    // state register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= SCAN;
        else        state <= state_nxt;
    end

    // next state: two drain cycles let the last read land before reporting
    always_comb begin
        state_nxt = state;
        case (state)
            SCAN:    if (bus.scan_done) state_nxt = DRAIN1;
            DRAIN1:  state_nxt = DRAIN2;
            DRAIN2:  state_nxt = REPORT;
            REPORT:  state_nxt = SCAN;
            default: state_nxt = SCAN;
        endcase
    end

    // issue map read one cycle after the sample; rd_pend marks the data cycle
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rd_q    <= 1'b0;
            addr_q  <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_q    <= accept;
            rd_pend <= rd_q;
            if (accept) addr_q <= addr_calc;
        end
    end

    // coin accumulator: saturating, cleared when the round is published
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            coin_acc <= '0;
        else if (state == REPORT)
            coin_acc <= '0;
        else if (rd_pend && bus.map_rd_data == COIN_CODE && coin_acc != '1)
            coin_acc <= coin_acc + 1'b1;
    end

    // publish round result on the edge leaving REPORT
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            coins_q <= '0;
            clear_q <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            rv_q <= (state == REPORT);
            if (state == REPORT) begin
                coins_q <= coin_acc;
                clear_q <= (coin_acc == '0);
            end
        end
    end

`ifdef TALLY_WALL_COUNT_EN
    logic [COUNT_W-1:0] wall_acc;
    logic [COUNT_W-1:0] wall_q;

    // wall accumulator and its published copy, same timing as the coin tally
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wall_acc <= '0;
            wall_q   <= '0;
        end else if (state == REPORT) begin
            wall_q   <= wall_acc;
            wall_acc <= '0;
        end else if (rd_pend && bus.map_rd_data == WALL_CODE && wall_acc != '1) begin
            wall_acc <= wall_acc + 1'b1;
        end
    end

    assign bus.wall_count = wall_q;
`else
    logic unused_wall_code;
    assign unused_wall_code = ^WALL_CODE;
    assign bus.wall_count   = '0;
`endif

    assign bus.map_rd      = rd_q;
    assign bus.map_addr    = addr_q;
    assign bus.coins_left  = coins_q;
    assign bus.level_clear = clear_q;
    assign bus.round_valid = rv_q;
endmodule
